psum_deskew_fifo: RTL and testbench

PSUM_DESKEW_FIFO -- requirements
Module: psum_deskew_fifo

---
 rtl/psum_deskew_fifo.sv | 121 ++++++++++++
 tb/tb_psum_deskew_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_deskew_fifo.sv
// Partial-sum deskew and output FIFO for the bottom row of a systolic array.
// Column j arrives j cycles after column 0, so it is delayed by N-j stages to
// line all columns up. Fully valid rows are queued in a show-ahead FIFO.
// Partially valid rows are discarded and flagged.
module psum_deskew_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [N*32-1:0]        col_psum_in,
  input  logic [N-1:0]           col_valid_in,
  output logic [N*32-1:0]        out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   skew_err,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  // Aligned row at the deskew output.
  logic [N*32-1:0] desk_data;
  logic [N-1:0]    desk_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      localparam int STAGES = N - gi;
      logic [31:0]       data_pipe [STAGES];
      logic [STAGES-1:0] valid_pipe;

      // Delay line for this column. Data is captured every cycle.
      // Valid bits are flushed by clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < STAGES; s++) data_pipe[s] <= '0;
          valid_pipe <= '0;
        end else begin
          data_pipe[0]  <= col_psum_in[32*gi +: 32];
          valid_pipe[0] <= clear ? 1'b0 : col_valid_in[gi];
          for (int s = 1; s < STAGES; s++) begin
            data_pipe[s]  <= data_pipe[s-1];
            valid_pipe[s] <= clear ? 1'b0 : valid_pipe[s-1];
          end
        end
      end

      assign desk_data[32*gi +: 32] = data_pipe[STAGES-1];
      assign desk_valid[gi]         = valid_pipe[STAGES-1];
    end
  endgenerate

  logic [N*32-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            skew_reg;
  logic            ovf_reg;

  logic row_complete;
  logic row_partial;
  logic fifo_full;
  logic push;
  logic pop;

  assign row_complete = &desk_valid;
  assign row_partial  = (|desk_valid) && !row_complete;
  assign fifo_full    = (count_reg == (AW+1)'(DEPTH));
  assign pop          = out_valid && out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push         = row_complete && (!fifo_full || pop);

  assign out_valid  = (count_reg != '0);
  assign out_data   = mem[rd_ptr_reg];
  assign fifo_count = count_reg;
  assign skew_err   = skew_reg;
  assign overflow   = ovf_reg;

  // Compute the next occupancy from push and pop.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage. It has no reset because its contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_reg] <= desk_data;
  end

  // Pointers, count and sticky flags. Clear wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      skew_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      skew_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (row_partial) skew_reg <= 1'b1;
      if (row_complete && fifo_full && !pop) ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_deskew_fifo.sv
// Randomized and directed bench for psum_deskew_fifo.
// The reference model rebuilds each aligned row from the input history.
// The history is indexed by cycle.
// The FIFO itself is modelled as a queue.
module tb_psum_deskew_fifo;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int MAXC  = 2048;
  localparam int W     = N*32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   clear = 1'b0;
  logic [W-1:0]           col_psum_in = '0;
  logic [N-1:0]           col_valid_in = '0;
  logic [W-1:0]           out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   skew_err;
  logic                   overflow;

  psum_deskew_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .col_psum_in(col_psum_in), .col_valid_in(col_valid_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .skew_err(skew_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Input history and model state.
  logic [31:0]  hd [MAXC][N];
  bit           hv [MAXC][N];
  int           t = 0;
  int           epoch = 0;
  logic [W-1:0] q[$];
  bit           m_skew = 0;
  bit           m_ovf = 0;

  logic [31:0]  cur_d [N];
  bit           cur_v [N];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got=%h expected=%h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: drive the inputs, compare the outputs with the model, and advance the model.
  task automatic step(input bit rdy, input bit clr);
    logic [N-1:0] dv;
    logic [W-1:0] dd;
    int s, sz;
    bit full, pop, complete, partial;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget: got=%0d limit=%0d", t, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    @(negedge clk);
    for (int j = 0; j < N; j++) begin
      col_psum_in[32*j +: 32] = cur_d[j];
      col_valid_in[j]         = cur_v[j];
      hd[t][j] = cur_d[j];
      hv[t][j] = cur_v[j];
    end
    out_ready = rdy;
    clear     = clr;
    chk("out_valid", W'(out_valid), W'(q.size() != 0));
    chk("fifo_count", W'(fifo_count), W'(q.size()));
    chk("skew_err", W'(skew_err), W'(m_skew));
    chk("overflow", W'(overflow), W'(m_ovf));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    // Column j seen at the aligned output in cycle t was presented in cycle t-(N-j).
    for (int j = 0; j < N; j++) begin
      s = t - (N - j);
      dv[j] = (s >= epoch) ? hv[s][j] : 1'b0;
      dd[32*j +: 32] = (s >= 0) ? hd[s][j] : 32'h0;
    end
    sz = q.size();
    full = (sz == DEPTH);
    pop = (sz > 0) && rdy;
    complete = (dv == {N{1'b1}});
    partial = (dv != '0) && !complete;
    if (clr) begin
      q.delete();
      m_skew = 0;
      m_ovf = 0;
      epoch = t + 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (complete) begin
        if (!full || pop) q.push_back(dd);
        else m_ovf = 1;
      end
      if (partial) m_skew = 1;
    end
    @(posedge clk);
    t++;
  endtask

  task automatic zero_inputs();
    for (int j = 0; j < N; j++) begin
      cur_d[j] = '0;
      cur_v[j] = 0;
    end
  endtask

  task automatic idle(input int n, input bit rdy, input bit clr);
    zero_inputs();
    for (int k = 0; k < n; k++) step(rdy, clr && (k == 0));
  endtask

  // Skewed rows: row r, column j is presented at relative cycle r+j.
  task automatic run_rows(input int nrows, input int tail, input bit rdy_all, input int rdy_k,
                          input logic [31:0] base, input bit vary);
    int r;
    for (int k = 0; k < nrows + N - 1 + tail; k++) begin
      for (int j = 0; j < N; j++) begin
        r = k - j;
        cur_v[j] = (r >= 0) && (r < nrows);
        cur_d[j] = cur_v[j] ? (vary ? base + 32'(r*16 + j) : base) : 32'h0;
      end
      step(rdy_all || (k == rdy_k), 0);
    end
  endtask

  // Asynchronous reset at a negedge. Outputs are checked while rst is still high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    col_valid_in = '0;
    col_psum_in = '0;
    clear = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_fifo_count", W'(fifo_count), W'(0));
    chk("rst_skew_err", W'(skew_err), W'(0));
    chk("rst_overflow", W'(overflow), W'(0));
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < N; j++) begin
        hd[t][j] = '0;
        hv[t][j] = 0;
      end
      @(posedge clk);
      t++;
    end
    #1 rst = 1'b0;
    q.delete();
    m_skew = 0;
    m_ovf = 0;
    epoch = t;
  endtask

  bit rs [MAXC];

  initial begin
    int p, j0;
    zero_inputs();
    do_reset();

    // Single row of 1, 2, 3, 4.
    run_rows(1, 3, 0, -1, 32'd1, 1);
    #1;
    chk("single_data", out_data, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("single_count", W'(fifo_count), W'(1));

    // Nine rows into an eight-entry FIFO with no consumer, then drain.
    idle(1, 0, 1);
    run_rows(9, 3, 0, -1, 32'h100, 1);
    #1;
    chk("fill_count", W'(fifo_count), W'(DEPTH));
    chk("fill_overflow", W'(overflow), W'(1));
    idle(10, 1, 0);

    // Full FIFO and a row completing in the same cycle as a pop.
    idle(1, 0, 1);
    run_rows(8, 2, 0, -1, 32'h2000, 1);
    run_rows(1, 1, 0, N, 32'h9000, 1);
    #1;
    chk("fullpop_overflow", W'(overflow), W'(0));
    chk("fullpop_count", W'(fifo_count), W'(DEPTH));
    idle(10, 1, 0);

    // Skew fault: column 1 arrives one cycle early.
    idle(1, 0, 1);
    for (int k = 0; k < 7; k++) begin
      zero_inputs();
      if (k == 0) begin
        cur_v[0] = 1; cur_d[0] = 32'h11;
        cur_v[1] = 1; cur_d[1] = 32'h22;
      end
      if (k == 2) begin cur_v[2] = 1; cur_d[2] = 32'h33; end
      if (k == 3) begin cur_v[3] = 1; cur_d[3] = 32'h44; end
      step(0, 0);
    end
    #1;
    chk("skew_flag", W'(skew_err), W'(1));
    chk("skew_count", W'(fifo_count), W'(0));
    idle(2, 0, 1);

    // Negative data, streaming with the consumer always ready.
    run_rows(12, 3, 1, -1, 32'hFFFF_FFFF, 0);

    // Reset with three entries queued and two rows in flight.
    idle(1, 0, 1);
    run_rows(3, 1, 0, -1, 32'h3000, 1);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < N; j++) begin
        cur_v[j] = (k - j >= 0);
        cur_d[j] = cur_v[j] ? 32'h4000 + 32'(j) : 32'h0;
      end
      step(0, 0);
    end
    do_reset();
    idle(8, 1, 0);

    // Random traffic with occasional skew faults, clears and ready bursts.
    for (int k = 0; k < 600; k++) begin
      rs[k] = ($urandom_range(0, 99) < 60);
      for (int j = 0; j < N; j++) begin
        cur_v[j] = (k - j >= 0) && rs[k-j];
        cur_d[j] = cur_v[j] ? $urandom : 32'h0;
      end
      if ($urandom_range(0, 99) < 3) begin
        j0 = $urandom_range(0, N-1);
        cur_v[j0] = !cur_v[j0];
        if (cur_v[j0]) cur_d[j0] = $urandom;
        else cur_d[j0] = 32'h0;
      end
      p = ((k / 50) % 2 == 1) ? 15 : 85;
      step($urandom_range(0, 99) < p, $urandom_range(0, 149) == 0);
    end
    idle(12, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
